// File: rtl/ux607_tlbuffer_qspi_1.sv
// ux607_tlbuffer_qspi_1
//   TileLink buffer between the QSPI fragmenter (io_in_0) and the QSPI flash
//   controller slave port (io_out_0). A and D each pass through an independent
//   circular queue that registers valid/ready. B/C/E are constant tie-offs.
//   Optional feature macro: UX607_TLBUF_QSPI_FLOW_EN (flow-through when empty).

// Generic circular queue used for both the A and D channels.
module ux607_tlbuffer_qspi_1_queue #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clock,
   input  logic             reset,
   output logic             in_ready,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_bits,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_bits
);
   // A single-entry queue has no pointer state; keep one bit that never moves.
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] storage [DEPTH];
   logic [PW-1:0]    enq_ptr;
   logic [PW-1:0]    deq_ptr;
   logic             maybe_full;
   logic             ptr_match;
   logic             empty;
   logic             full;
   logic             enq;
   logic             deq;
   logic             do_enq;
   logic             do_deq;

   assign ptr_match = (enq_ptr == deq_ptr);
   assign empty     = ptr_match & ~maybe_full;
   assign full      = ptr_match & maybe_full;

   // Readiness depends only on occupancy, never on the downstream ready.
   assign in_ready  = ~full;
   assign enq       = in_valid & in_ready;
   assign deq       = out_valid & out_ready;

`ifdef UX607_TLBUF_QSPI_FLOW_EN
   // When empty, the incoming beat is presented directly; if taken in the same
   // cycle it never touches storage, pointers or the full flag.
   assign out_valid = ~empty | in_valid;
   assign out_bits  = empty ? in_bits : storage[deq_ptr];
   assign do_enq    = enq & ~(empty & out_ready);
   assign do_deq    = deq & ~empty;
`else
   assign out_valid = ~empty;
   assign out_bits  = storage[deq_ptr];
   assign do_enq    = enq;
   assign do_deq    = deq;
`endif

   // Pointer and occupancy-flag update; this is the only state cleared by reset.
   always_ff @(posedge clock or posedge reset) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         enq_ptr    <= '0;
         deq_ptr    <= '0;
         maybe_full <= 1'b0;
      end else begin
         if (do_enq) enq_ptr <= (DEPTH == 1) ? '0 : enq_ptr + 1'b1;
         if (do_deq) deq_ptr <= (DEPTH == 1) ? '0 : deq_ptr + 1'b1;
         if (do_enq != do_deq) maybe_full <= do_enq;
      end
   end

   // Payload write into the slot addressed by the enqueue pointer.
   always_ff @(posedge clock) begin
      // NOTE: storage has no reset; empty/full flags alone decide what is valid.
      if (do_enq) storage[enq_ptr] <= in_bits;
   end

endmodule

module ux607_tlbuffer_qspi_1 #(
   parameter int A_DEPTH = 2,
   parameter int D_DEPTH = 2
) (
   input  logic        clock,
   input  logic        reset,
   // fragmenter side: A in, D out
   output logic        io_in_0_a_ready,
   input  logic        io_in_0_a_valid,
   input  logic [2:0]  io_in_0_a_bits_opcode,
   input  logic [2:0]  io_in_0_a_bits_param,
   input  logic [2:0]  io_in_0_a_bits_size,
   input  logic [6:0]  io_in_0_a_bits_source,
   input  logic [29:0] io_in_0_a_bits_address,
   input  logic [0:0]  io_in_0_a_bits_mask,
   input  logic [7:0]  io_in_0_a_bits_data,
   input  logic        io_in_0_d_ready,
   output logic        io_in_0_d_valid,
   output logic [2:0]  io_in_0_d_bits_opcode,
   output logic [1:0]  io_in_0_d_bits_param,
   output logic [2:0]  io_in_0_d_bits_size,
   output logic [6:0]  io_in_0_d_bits_source,
   output logic [0:0]  io_in_0_d_bits_sink,
   output logic [0:0]  io_in_0_d_bits_addr_lo,
   output logic [7:0]  io_in_0_d_bits_data,
   output logic        io_in_0_d_bits_error,
   // fragmenter side: B/C/E tie-offs
   input  logic        io_in_0_b_ready,
   output logic        io_in_0_b_valid,
   output logic [2:0]  io_in_0_b_bits_opcode,
   output logic [1:0]  io_in_0_b_bits_param,
   output logic [2:0]  io_in_0_b_bits_size,
   output logic [6:0]  io_in_0_b_bits_source,
   output logic [29:0] io_in_0_b_bits_address,
   output logic [0:0]  io_in_0_b_bits_mask,
   output logic [7:0]  io_in_0_b_bits_data,
   output logic        io_in_0_c_ready,
   input  logic        io_in_0_c_valid,
   output logic        io_in_0_e_ready,
   input  logic        io_in_0_e_valid,
   // controller side: A out, D in
   input  logic        io_out_0_a_ready,
   output logic        io_out_0_a_valid,
   output logic [2:0]  io_out_0_a_bits_opcode,
   output logic [2:0]  io_out_0_a_bits_param,
   output logic [2:0]  io_out_0_a_bits_size,
   output logic [6:0]  io_out_0_a_bits_source,
   output logic [29:0] io_out_0_a_bits_address,
   output logic [0:0]  io_out_0_a_bits_mask,
   output logic [7:0]  io_out_0_a_bits_data,
   output logic        io_out_0_d_ready,
   input  logic        io_out_0_d_valid,
   input  logic [2:0]  io_out_0_d_bits_opcode,
   input  logic [1:0]  io_out_0_d_bits_param,
   input  logic [2:0]  io_out_0_d_bits_size,
   input  logic [6:0]  io_out_0_d_bits_source,
   input  logic [0:0]  io_out_0_d_bits_sink,
   input  logic [0:0]  io_out_0_d_bits_addr_lo,
   input  logic [7:0]  io_out_0_d_bits_data,
   input  logic        io_out_0_d_bits_error,
   // controller side: B/C/E tie-offs
   output logic        io_out_0_b_ready,
   input  logic        io_out_0_b_valid,
   input  logic        io_out_0_c_ready,
   output logic        io_out_0_c_valid,
   output logic [2:0]  io_out_0_c_bits_opcode,
   output logic [2:0]  io_out_0_c_bits_param,
   output logic [2:0]  io_out_0_c_bits_size,
   output logic [6:0]  io_out_0_c_bits_source,
   output logic [29:0] io_out_0_c_bits_address,
   output logic [7:0]  io_out_0_c_bits_data,
   input  logic        io_out_0_e_ready,
   output logic        io_out_0_e_valid,
   output logic [0:0]  io_out_0_e_bits_sink
);
   localparam int A_W = 3 + 3 + 3 + 7 + 30 + 1 + 8;
   localparam int D_W = 3 + 2 + 3 + 7 + 1 + 1 + 8 + 1;

   logic [A_W-1:0] a_enq_bits;
   logic [A_W-1:0] a_deq_bits;
   logic [D_W-1:0] d_enq_bits;
   logic [D_W-1:0] d_deq_bits;
   logic           unused_tieoff_inputs;

   // Fields travel verbatim as one packed word per channel.
   assign a_enq_bits = {io_in_0_a_bits_opcode, io_in_0_a_bits_param, io_in_0_a_bits_size,
                        io_in_0_a_bits_source, io_in_0_a_bits_address, io_in_0_a_bits_mask,
                        io_in_0_a_bits_data};
   assign {io_out_0_a_bits_opcode, io_out_0_a_bits_param, io_out_0_a_bits_size,
           io_out_0_a_bits_source, io_out_0_a_bits_address, io_out_0_a_bits_mask,
           io_out_0_a_bits_data} = a_deq_bits;

   assign d_enq_bits = {io_out_0_d_bits_opcode, io_out_0_d_bits_param, io_out_0_d_bits_size,
                        io_out_0_d_bits_source, io_out_0_d_bits_sink, io_out_0_d_bits_addr_lo,
                        io_out_0_d_bits_data, io_out_0_d_bits_error};
   assign {io_in_0_d_bits_opcode, io_in_0_d_bits_param, io_in_0_d_bits_size,
           io_in_0_d_bits_source, io_in_0_d_bits_sink, io_in_0_d_bits_addr_lo,
           io_in_0_d_bits_data, io_in_0_d_bits_error} = d_deq_bits;

   ux607_tlbuffer_qspi_1_queue #(.WIDTH(A_W), .DEPTH(A_DEPTH)) u_a_queue (
      .clock     (clock),
      .reset     (reset),
      .in_ready  (io_in_0_a_ready),
      .in_valid  (io_in_0_a_valid),
      .in_bits   (a_enq_bits),
      .out_ready (io_out_0_a_ready),
      .out_valid (io_out_0_a_valid),
      .out_bits  (a_deq_bits)
   );

   ux607_tlbuffer_qspi_1_queue #(.WIDTH(D_W), .DEPTH(D_DEPTH)) u_d_queue (
      .clock     (clock),
      .reset     (reset),
      .in_ready  (io_out_0_d_ready),
      .in_valid  (io_out_0_d_valid),
      .in_bits   (d_enq_bits),
      .out_ready (io_in_0_d_ready),
      .out_valid (io_in_0_d_valid),
      .out_bits  (d_deq_bits)
   );

   // B/C/E are unused by the QSPI slave: never issue, always accept.
   assign io_in_0_b_valid         = 1'b0;
   assign io_in_0_b_bits_opcode   = '0;
   assign io_in_0_b_bits_param    = '0;
   assign io_in_0_b_bits_size     = '0;
   assign io_in_0_b_bits_source   = '0;
   assign io_in_0_b_bits_address  = '0;
   assign io_in_0_b_bits_mask     = '0;
   assign io_in_0_b_bits_data     = '0;
   assign io_in_0_c_ready         = 1'b1;
   assign io_in_0_e_ready         = 1'b1;
   assign io_out_0_b_ready        = 1'b1;
   assign io_out_0_c_valid        = 1'b0;
   assign io_out_0_c_bits_opcode  = '0;
   assign io_out_0_c_bits_param   = '0;
   assign io_out_0_c_bits_size    = '0;
   assign io_out_0_c_bits_source  = '0;
   assign io_out_0_c_bits_address = '0;
   assign io_out_0_c_bits_data    = '0;
   assign io_out_0_e_valid        = 1'b0;
   assign io_out_0_e_bits_sink    = '0;

   assign unused_tieoff_inputs = ^{io_in_0_b_ready, io_in_0_c_valid, io_in_0_e_valid,
                                   io_out_0_b_valid, io_out_0_c_ready, io_out_0_e_ready};

   // A request offered to the controller must stay valid until it is accepted.
   a_valid_held: assert property (@(posedge clock) disable iff (reset)
      (io_out_0_a_valid && !io_out_0_a_ready) |=> io_out_0_a_valid)
      else $error("ux607_tlbuffer_qspi_1: io_out_0_a_valid dropped before handshake");

endmodule

// File: tb/tb_ux607_tlbuffer_qspi_1.sv
// Self-checking bench for ux607_tlbuffer_qspi_1: directed vectors plus random
// valid/ready traffic, checked by per-channel scoreboards.
`timescale 1ns/1ps
module tb_ux607_tlbuffer_qspi_1;
   localparam int N_RAND = 10000;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic        io_in_0_a_ready, io_in_0_a_valid;
   logic [2:0]  io_in_0_a_bits_opcode, io_in_0_a_bits_param, io_in_0_a_bits_size;
   logic [6:0]  io_in_0_a_bits_source;
   logic [29:0] io_in_0_a_bits_address;
   logic [0:0]  io_in_0_a_bits_mask;
   logic [7:0]  io_in_0_a_bits_data;
   logic        io_in_0_d_ready, io_in_0_d_valid;
   logic [2:0]  io_in_0_d_bits_opcode;
   logic [1:0]  io_in_0_d_bits_param;
   logic [2:0]  io_in_0_d_bits_size;
   logic [6:0]  io_in_0_d_bits_source;
   logic [0:0]  io_in_0_d_bits_sink, io_in_0_d_bits_addr_lo;
   logic [7:0]  io_in_0_d_bits_data;
   logic        io_in_0_d_bits_error;
   logic        io_in_0_b_ready, io_in_0_b_valid;
   logic [2:0]  io_in_0_b_bits_opcode;
   logic [1:0]  io_in_0_b_bits_param;
   logic [2:0]  io_in_0_b_bits_size;
   logic [6:0]  io_in_0_b_bits_source;
   logic [29:0] io_in_0_b_bits_address;
   logic [0:0]  io_in_0_b_bits_mask;
   logic [7:0]  io_in_0_b_bits_data;
   logic        io_in_0_c_ready, io_in_0_c_valid, io_in_0_e_ready, io_in_0_e_valid;
   logic        io_out_0_a_ready, io_out_0_a_valid;
   logic [2:0]  io_out_0_a_bits_opcode, io_out_0_a_bits_param, io_out_0_a_bits_size;
   logic [6:0]  io_out_0_a_bits_source;
   logic [29:0] io_out_0_a_bits_address;
   logic [0:0]  io_out_0_a_bits_mask;
   logic [7:0]  io_out_0_a_bits_data;
   logic        io_out_0_d_ready, io_out_0_d_valid;
   logic [2:0]  io_out_0_d_bits_opcode;
   logic [1:0]  io_out_0_d_bits_param;
   logic [2:0]  io_out_0_d_bits_size;
   logic [6:0]  io_out_0_d_bits_source;
   logic [0:0]  io_out_0_d_bits_sink, io_out_0_d_bits_addr_lo;
   logic [7:0]  io_out_0_d_bits_data;
   logic        io_out_0_d_bits_error;
   logic        io_out_0_b_ready, io_out_0_b_valid, io_out_0_c_ready, io_out_0_c_valid;
   logic [2:0]  io_out_0_c_bits_opcode, io_out_0_c_bits_param, io_out_0_c_bits_size;
   logic [6:0]  io_out_0_c_bits_source;
   logic [29:0] io_out_0_c_bits_address;
   logic [7:0]  io_out_0_c_bits_data;
   logic        io_out_0_e_ready, io_out_0_e_valid;
   logic [0:0]  io_out_0_e_bits_sink;

   ux607_tlbuffer_qspi_1 dut (
      .clock(clock), .reset(reset),
      .io_in_0_a_ready(io_in_0_a_ready), .io_in_0_a_valid(io_in_0_a_valid),
      .io_in_0_a_bits_opcode(io_in_0_a_bits_opcode), .io_in_0_a_bits_param(io_in_0_a_bits_param),
      .io_in_0_a_bits_size(io_in_0_a_bits_size), .io_in_0_a_bits_source(io_in_0_a_bits_source),
      .io_in_0_a_bits_address(io_in_0_a_bits_address), .io_in_0_a_bits_mask(io_in_0_a_bits_mask),
      .io_in_0_a_bits_data(io_in_0_a_bits_data),
      .io_in_0_d_ready(io_in_0_d_ready), .io_in_0_d_valid(io_in_0_d_valid),
      .io_in_0_d_bits_opcode(io_in_0_d_bits_opcode), .io_in_0_d_bits_param(io_in_0_d_bits_param),
      .io_in_0_d_bits_size(io_in_0_d_bits_size), .io_in_0_d_bits_source(io_in_0_d_bits_source),
      .io_in_0_d_bits_sink(io_in_0_d_bits_sink), .io_in_0_d_bits_addr_lo(io_in_0_d_bits_addr_lo),
      .io_in_0_d_bits_data(io_in_0_d_bits_data), .io_in_0_d_bits_error(io_in_0_d_bits_error),
      .io_in_0_b_ready(io_in_0_b_ready), .io_in_0_b_valid(io_in_0_b_valid),
      .io_in_0_b_bits_opcode(io_in_0_b_bits_opcode), .io_in_0_b_bits_param(io_in_0_b_bits_param),
      .io_in_0_b_bits_size(io_in_0_b_bits_size), .io_in_0_b_bits_source(io_in_0_b_bits_source),
      .io_in_0_b_bits_address(io_in_0_b_bits_address), .io_in_0_b_bits_mask(io_in_0_b_bits_mask),
      .io_in_0_b_bits_data(io_in_0_b_bits_data),
      .io_in_0_c_ready(io_in_0_c_ready), .io_in_0_c_valid(io_in_0_c_valid),
      .io_in_0_e_ready(io_in_0_e_ready), .io_in_0_e_valid(io_in_0_e_valid),
      .io_out_0_a_ready(io_out_0_a_ready), .io_out_0_a_valid(io_out_0_a_valid),
      .io_out_0_a_bits_opcode(io_out_0_a_bits_opcode), .io_out_0_a_bits_param(io_out_0_a_bits_param),
      .io_out_0_a_bits_size(io_out_0_a_bits_size), .io_out_0_a_bits_source(io_out_0_a_bits_source),
      .io_out_0_a_bits_address(io_out_0_a_bits_address), .io_out_0_a_bits_mask(io_out_0_a_bits_mask),
      .io_out_0_a_bits_data(io_out_0_a_bits_data),
      .io_out_0_d_ready(io_out_0_d_ready), .io_out_0_d_valid(io_out_0_d_valid),
      .io_out_0_d_bits_opcode(io_out_0_d_bits_opcode), .io_out_0_d_bits_param(io_out_0_d_bits_param),
      .io_out_0_d_bits_size(io_out_0_d_bits_size), .io_out_0_d_bits_source(io_out_0_d_bits_source),
      .io_out_0_d_bits_sink(io_out_0_d_bits_sink), .io_out_0_d_bits_addr_lo(io_out_0_d_bits_addr_lo),
      .io_out_0_d_bits_data(io_out_0_d_bits_data), .io_out_0_d_bits_error(io_out_0_d_bits_error),
      .io_out_0_b_ready(io_out_0_b_ready), .io_out_0_b_valid(io_out_0_b_valid),
      .io_out_0_c_ready(io_out_0_c_ready), .io_out_0_c_valid(io_out_0_c_valid),
      .io_out_0_c_bits_opcode(io_out_0_c_bits_opcode), .io_out_0_c_bits_param(io_out_0_c_bits_param),
      .io_out_0_c_bits_size(io_out_0_c_bits_size), .io_out_0_c_bits_source(io_out_0_c_bits_source),
      .io_out_0_c_bits_address(io_out_0_c_bits_address), .io_out_0_c_bits_data(io_out_0_c_bits_data),
      .io_out_0_e_ready(io_out_0_e_ready), .io_out_0_e_valid(io_out_0_e_valid),
      .io_out_0_e_bits_sink(io_out_0_e_bits_sink)
   );

   int checks = 0;
   int errors = 0;
   int a_pops = 0;
   int d_pops = 0;
   int tie_bad = 0;
   int a_base, d_base;
   bit a_done = 1'b0;
   bit d_done = 1'b0;
   logic [54:0] exp_a [$];
   logic [25:0] exp_d [$];

   logic [54:0] a_in_pack, a_out_pack;
   logic [25:0] d_in_pack, d_out_pack;
   assign a_in_pack  = {io_in_0_a_bits_opcode, io_in_0_a_bits_param, io_in_0_a_bits_size,
                        io_in_0_a_bits_source, io_in_0_a_bits_address, io_in_0_a_bits_mask,
                        io_in_0_a_bits_data};
   assign a_out_pack = {io_out_0_a_bits_opcode, io_out_0_a_bits_param, io_out_0_a_bits_size,
                        io_out_0_a_bits_source, io_out_0_a_bits_address, io_out_0_a_bits_mask,
                        io_out_0_a_bits_data};
   assign d_in_pack  = {io_out_0_d_bits_opcode, io_out_0_d_bits_param, io_out_0_d_bits_size,
                        io_out_0_d_bits_source, io_out_0_d_bits_sink, io_out_0_d_bits_addr_lo,
                        io_out_0_d_bits_data, io_out_0_d_bits_error};
   assign d_out_pack = {io_in_0_d_bits_opcode, io_in_0_d_bits_param, io_in_0_d_bits_size,
                        io_in_0_d_bits_source, io_in_0_d_bits_sink, io_in_0_d_bits_addr_lo,
                        io_in_0_d_bits_data, io_in_0_d_bits_error};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 'h%0h, required 'h%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_a(input logic [2:0] op, input logic [2:0] prm, input logic [2:0] sz,
                        input logic [6:0] src, input logic [29:0] addr, input logic m,
                        input logic [7:0] dat);
      io_in_0_a_bits_opcode  = op;
      io_in_0_a_bits_param   = prm;
      io_in_0_a_bits_size    = sz;
      io_in_0_a_bits_source  = src;
      io_in_0_a_bits_address = addr;
      io_in_0_a_bits_mask    = m;
      io_in_0_a_bits_data    = dat;
   endtask

   task automatic set_d(input logic [2:0] op, input logic [1:0] prm, input logic [2:0] sz,
                        input logic [6:0] src, input logic snk, input logic alo,
                        input logic [7:0] dat, input logic err);
      io_out_0_d_bits_opcode  = op;
      io_out_0_d_bits_param   = prm;
      io_out_0_d_bits_size    = sz;
      io_out_0_d_bits_source  = src;
      io_out_0_d_bits_sink    = snk;
      io_out_0_d_bits_addr_lo = alo;
      io_out_0_d_bits_data    = dat;
      io_out_0_d_bits_error   = err;
   endtask

   // Hold the A request until the buffer accepts it (bounded wait).
   task automatic send_a_beat(output bit ok);
      int guard;
      guard = 0;
      io_in_0_a_valid = 1'b1;
      @(negedge clock);
      while (!io_in_0_a_ready && guard < 1000) begin
         @(negedge clock);
         guard++;
      end
      ok = io_in_0_a_ready;
      step();
      io_in_0_a_valid = 1'b0;
   endtask

   // Hold the D response until the buffer accepts it (bounded wait).
   task automatic send_d_beat(output bit ok);
      int guard;
      guard = 0;
      io_out_0_d_valid = 1'b1;
      @(negedge clock);
      while (!io_out_0_d_ready && guard < 1000) begin
         @(negedge clock);
         guard++;
      end
      ok = io_out_0_d_ready;
      step();
      io_out_0_d_valid = 1'b0;
   endtask

   // A scoreboard: record accepted requests, compare as they reach the controller.
   always @(negedge clock) begin
      if (reset) exp_a.delete();
      else begin
         if (io_in_0_a_valid && io_in_0_a_ready) exp_a.push_back(a_in_pack);
         if (io_out_0_a_valid && io_out_0_a_ready) begin
            a_pops++;
            if (exp_a.size() == 0) check("a_unexpected_beat", 64'd1, 64'd0);
            else check("a_beat", a_out_pack, exp_a.pop_front());
         end
      end
   end

   // D scoreboard: record accepted responses, compare as they reach the fragmenter.
   always @(negedge clock) begin
      if (reset) exp_d.delete();
      else begin
         if (io_out_0_d_valid && io_out_0_d_ready) exp_d.push_back(d_in_pack);
         if (io_in_0_d_valid && io_in_0_d_ready) begin
            d_pops++;
            if (exp_d.size() == 0) check("d_unexpected_beat", 64'd1, 64'd0);
            else check("d_beat", d_out_pack, exp_d.pop_front());
         end
      end
   end

   // Tie-offs must be constant in every cycle, reset included.
   always @(negedge clock) begin
      if ({io_in_0_b_valid, io_in_0_b_bits_opcode, io_in_0_b_bits_param, io_in_0_b_bits_size,
           io_in_0_b_bits_source, io_in_0_b_bits_address, io_in_0_b_bits_mask, io_in_0_b_bits_data,
           io_out_0_c_valid, io_out_0_c_bits_opcode, io_out_0_c_bits_param, io_out_0_c_bits_size,
           io_out_0_c_bits_source, io_out_0_c_bits_address, io_out_0_c_bits_data,
           io_out_0_e_valid, io_out_0_e_bits_sink} != '0 ||
          {io_in_0_c_ready, io_in_0_e_ready, io_out_0_b_ready} != 3'b111)
         tie_bad++;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit ok;
      io_in_0_a_valid = 1'b0;  io_out_0_a_ready = 1'b1;
      io_out_0_d_valid = 1'b0; io_in_0_d_ready = 1'b1;
      io_in_0_b_ready = 1'b1;  io_in_0_c_valid = 1'b0; io_in_0_e_valid = 1'b0;
      io_out_0_b_valid = 1'b0; io_out_0_c_ready = 1'b1; io_out_0_e_ready = 1'b1;
      set_a(3'd0, 3'd0, 3'd0, 7'd0, 30'd0, 1'b0, 8'd0);
      set_d(3'd0, 2'd0, 3'd0, 7'd0, 1'b0, 1'b0, 8'd0, 1'b0);

      // Reset state
      step(); step();
      reset = 1'b0;
      @(negedge clock);
      check("rst_out_a_valid", io_out_0_a_valid, 64'd0);
      check("rst_in_d_valid", io_in_0_d_valid, 64'd0);
      check("rst_in_a_ready", io_in_0_a_ready, 64'd1);
      check("rst_out_d_ready", io_out_0_d_ready, 64'd1);
      step();

      // Single Get and its AccessAckData
      set_a(3'd4, 3'd0, 3'd0, 7'h25, 30'h100, 1'b1, 8'h00);
      io_in_0_a_valid = 1'b1;
      @(negedge clock);
      check("get_in_ready", io_in_0_a_ready, 64'd1);
`ifdef UX607_TLBUF_QSPI_FLOW_EN
      check("get_out_valid_c0", io_out_0_a_valid, 64'd1);
`else
      check("get_out_valid_c0", io_out_0_a_valid, 64'd0);
`endif
      step();
      io_in_0_a_valid = 1'b0;
      @(negedge clock);
`ifdef UX607_TLBUF_QSPI_FLOW_EN
      check("get_out_valid_c1", io_out_0_a_valid, 64'd0);
`else
      check("get_out_valid_c1", io_out_0_a_valid, 64'd1);
      check("get_out_addr", io_out_0_a_bits_address, 64'h100);
      check("get_out_source", io_out_0_a_bits_source, 64'h25);
`endif
      step();
      set_d(3'd1, 2'd0, 3'd0, 7'h25, 1'b0, 1'b0, 8'hA5, 1'b0);
      io_out_0_d_valid = 1'b1;
      @(negedge clock);
      check("ack_out_d_ready", io_out_0_d_ready, 64'd1);
      step();
      io_out_0_d_valid = 1'b0;
      @(negedge clock);
`ifndef UX607_TLBUF_QSPI_FLOW_EN
      check("ack_in_d_valid_c1", io_in_0_d_valid, 64'd1);
      check("ack_in_d_data", io_in_0_d_bits_data, 64'hA5);
`endif
      step(); step();

      // Backpressure, then full with simultaneous dequeue
      io_out_0_a_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_a(3'd0, 3'd0, 3'd0, 7'h40 + 7'(i), 30'h300 + 30'(i), 1'b1, 8'h10 + 8'(i));
         io_in_0_a_valid = 1'b1;
         @(negedge clock);
         check("bp_in_ready", io_in_0_a_ready, (i < 2) ? 64'd1 : 64'd0);
         if (i < 2) step();
      end
      step();
      @(negedge clock);
      check("bp_still_full", io_in_0_a_ready, 64'd0);
      step();
      io_out_0_a_ready = 1'b1;
      @(negedge clock);
      check("full_deq_in_ready", io_in_0_a_ready, 64'd0);
      check("full_deq_out_valid", io_out_0_a_valid, 64'd1);
      step();
      @(negedge clock);
      check("after_deq_in_ready", io_in_0_a_ready, 64'd1);
      step();
      io_in_0_a_valid = 1'b0;
      step(); step(); step();
      check("bp_drained", exp_a.size(), 64'd0);

      // Streaming: 32 beats each way with ready held high
      a_base = a_pops;
      d_base = d_pops;
      for (int i = 0; i < 32; i++) begin
         set_a(3'd0, 3'd0, 3'd0, 7'(i), 30'h200 + 30'(i), 1'b1, 8'(i));
         set_d(3'd1, 2'd0, 3'd0, 7'(i), 1'b0, 1'b0, 8'(i), 1'b0);
         io_in_0_a_valid  = 1'b1;
         io_out_0_d_valid = 1'b1;
         @(negedge clock);
         check("stream_readies", {io_in_0_a_ready, io_out_0_d_ready}, 64'd3);
         step();
      end
      io_in_0_a_valid  = 1'b0;
      io_out_0_d_valid = 1'b0;
      step(); step();
      check("stream_a_count", a_pops - a_base, 64'd32);
      check("stream_d_count", d_pops - d_base, 64'd32);

      // Reset mid-traffic
      io_out_0_a_ready = 1'b0;
      io_in_0_d_ready  = 1'b0;
      for (int i = 0; i < 2; i++) begin
         set_a(3'd1, 3'd0, 3'd0, 7'h10, 30'h400 + 30'(i), 1'b1, 8'hC0 + 8'(i));
         set_d(3'd0, 2'd0, 3'd0, 7'h10, 1'b0, 1'b0, 8'h00, 1'b0);
         io_in_0_a_valid  = 1'b1;
         io_out_0_d_valid = 1'b1;
         step();
      end
      io_in_0_a_valid  = 1'b0;
      io_out_0_d_valid = 1'b0;
      @(negedge clock);
      check("pre_rst_in_a_ready", io_in_0_a_ready, 64'd0);
      check("pre_rst_in_d_valid", io_in_0_d_valid, 64'd1);
      step();
      reset = 1'b1;
      step();
      @(negedge clock);
      check("midrst_out_a_valid", io_out_0_a_valid, 64'd0);
      check("midrst_in_d_valid", io_in_0_d_valid, 64'd0);
      check("midrst_in_a_ready", io_in_0_a_ready, 64'd1);
      check("midrst_out_d_ready", io_out_0_d_ready, 64'd1);
      reset = 1'b0;
      io_out_0_a_ready = 1'b1;
      io_in_0_d_ready  = 1'b1;
      step();
      @(negedge clock);
      check("postrst_out_a_valid", io_out_0_a_valid, 64'd0);
      step();

      // Random valid/ready on both channels
      fork
         begin
            for (int i = 0; i < N_RAND; i++) begin
               while ($urandom_range(3) == 0) step();
               set_a(3'($urandom), 3'($urandom), 3'($urandom), 7'($urandom), 30'($urandom),
                     1'($urandom), 8'($urandom));
               send_a_beat(ok);
               if (!ok) begin
                  check("rand_a_accept", 64'd0, 64'd1);
                  break;
               end
            end
            a_done = 1'b1;
         end
         begin
            int guard;
            guard = 0;
            while (!(a_done && exp_a.size() == 0) && guard < 40000) begin
               io_out_0_a_ready = ($urandom_range(3) != 0);
               step();
               guard++;
            end
            io_out_0_a_ready = 1'b1;
         end
         begin
            bit okd;
            for (int i = 0; i < N_RAND; i++) begin
               while ($urandom_range(3) == 0) step();
               set_d(3'($urandom), 2'($urandom), 3'($urandom), 7'($urandom), 1'($urandom),
                     1'($urandom), 8'($urandom), 1'($urandom));
               send_d_beat(okd);
               if (!okd) begin
                  check("rand_d_accept", 64'd0, 64'd1);
                  break;
               end
            end
            d_done = 1'b1;
         end
         begin
            int guard;
            guard = 0;
            while (!(d_done && exp_d.size() == 0) && guard < 40000) begin
               io_in_0_d_ready = ($urandom_range(3) != 0);
               step();
               guard++;
            end
            io_in_0_d_ready = 1'b1;
         end
      join
      step(); step();
      check("rand_a_drained", exp_a.size(), 64'd0);
      check("rand_d_drained", exp_d.size(), 64'd0);
      check("tieoffs_constant", tie_bad, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
